t2t_msg_seq: RTL and testbench

- Beat sequencer and field extractor for the 64-bit, three-beat market-data message stream.
- Accepts raw beats through a valid/ready handshake, tracks the beat position, and assembles symid, price and volume across beats.
- Forwards only NEW messages (type 24'h4E4557) as one decoded record to the downstream decision logic.
- Keeps saturating counters for passed, dropped and malformed messages.

---
 rtl/t2t_msg_seq.sv | 134 +++++++++++++
 tb/tb_t2t_msg_seq.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/t2t_msg_seq.sv
// rtl/t2t_msg_seq.sv - beat sequencer and field extractor for the three-beat market-data stream
// Assembles symid/price/volume across beats, filters on message type, keeps saturating stats.
module t2t_msg_seq #(
    parameter int CNT_WIDTH = 16,
    parameter bit FILTER_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sop,
    input  logic [63:0]          in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          out_symid,
    output logic [63:0]          out_price,
    output logic [31:0]          out_vol,
    output logic [23:0]          out_type,
    output logic [CNT_WIDTH-1:0] pass_cnt,
    output logic [CNT_WIDTH-1:0] drop_cnt,
    output logic [CNT_WIDTH-1:0] err_cnt
);

    localparam logic [23:0] TYPE_NEW = 24'h4E4557;

    typedef enum logic [1:0] {WAIT1, WAIT2, WAIT3, HOLD} state_t;

    state_t                 state_q;
    logic [23:0]            type_q;
    logic [15:0]            symid_q;
    logic [23:0]            price_up_q;
    logic [39:0]            price_dn_q;
    logic [23:0]            vol_up_q;
    logic [7:0]             vol_dn_q;
    logic [CNT_WIDTH-1:0]   pass_q;
    logic [CNT_WIDTH-1:0]   drop_q;
    logic [CNT_WIDTH-1:0]   err_q;

    logic                   beat_acc;
    logic [CNT_WIDTH-1:0]   pass_d;
    logic [CNT_WIDTH-1:0]   drop_d;
    logic [CNT_WIDTH-1:0]   err_d;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign beat_acc = in_valid && in_ready;
    assign pass_d   = sat_inc(pass_q);
    assign drop_d   = sat_inc(drop_q);
    assign err_d    = sat_inc(err_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= WAIT1;
            type_q     <= '0;
            symid_q    <= '0;
            price_up_q <= '0;
            price_dn_q <= '0;
            vol_up_q   <= '0;
            vol_dn_q   <= '0;
            pass_q     <= '0;
            drop_q     <= '0;
            err_q      <= '0;
        end else begin
            case (state_q)
                WAIT1: begin
                    if (beat_acc) begin
                        if (in_sop) begin
                            type_q     <= in_data[63:40];
                            symid_q    <= in_data[39:24];
                            price_up_q <= in_data[23:0];
                            state_q    <= WAIT2;
                        end else begin
                            err_q <= err_d;
                        end
                    end
                end
                WAIT2: begin
                    if (beat_acc) begin
                        if (in_sop) begin
                            err_q      <= err_d;
                            type_q     <= in_data[63:40];
                            symid_q    <= in_data[39:24];
                            price_up_q <= in_data[23:0];
                        end else begin
                            price_dn_q <= in_data[63:24];
                            vol_up_q   <= in_data[23:0];
                            state_q    <= WAIT3;
                        end
                    end
                end
                WAIT3: begin
                    if (beat_acc) begin
                        if (in_sop) begin
                            // An early sop restarts the message from this beat
                            err_q      <= err_d;
                            type_q     <= in_data[63:40];
                            symid_q    <= in_data[39:24];
                            price_up_q <= in_data[23:0];
                            state_q    <= WAIT2;
                        end else begin
                            vol_dn_q <= in_data[63:56];
                            if (!FILTER_EN || type_q == TYPE_NEW) begin
                                state_q <= HOLD;
                            end else begin
                                drop_q  <= drop_d;
                                state_q <= WAIT1;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        pass_q  <= pass_d;
                        state_q <= WAIT1;
                    end
                end
                default: state_q <= WAIT1;
            endcase
        end
    end

    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign out_symid = symid_q;
    assign out_price = {price_up_q, price_dn_q};
    assign out_vol   = {vol_up_q, vol_dn_q};
    assign out_type  = type_q;
    assign pass_cnt  = pass_q;
    assign drop_cnt  = drop_q;
    assign err_cnt   = err_q;

endmodule

// File: tb/tb_t2t_msg_seq.sv
// tb/tb_t2t_msg_seq.sv - self-checking bench for t2t_msg_seq
// Three instances: default, FILTER_EN=0, CNT_WIDTH=4; records checked against a per-instance queue.
module tb_t2t_msg_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  vld;
    logic        in_sop;
    logic [63:0] in_data;
    logic        out_ready;

    logic        rdy_a, rdy_b, rdy_c;
    logic        ov_a, ov_b, ov_c;
    logic [15:0] sym_a, sym_b, sym_c;
    logic [63:0] pr_a, pr_b, pr_c;
    logic [31:0] vol_a, vol_b, vol_c;
    logic [23:0] ty_a, ty_b, ty_c;
    logic [15:0] pass_a, drop_a, err_a;
    logic [15:0] pass_b, drop_b, err_b;
    logic [3:0]  pass_c, drop_c, err_c;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] symid;
        logic [63:0] price;
        logic [31:0] vol;
        logic [23:0] ty;
    } rec_t;

    typedef struct packed {
        logic [63:0] b1;
        logic [63:0] b2;
        logic [63:0] b3;
        logic        emit;
        rec_t        exp;
        logic [15:0] pass_e;
        logic [15:0] drop_e;
    } vec_t;

    rec_t q_a[$];
    rec_t q_b[$];
    rec_t q_c[$];
    vec_t vecs[5];

    always #5 clk = ~clk;

    t2t_msg_seq dut_a (
        .clk(clk), .reset(reset), .in_valid(vld[0]), .in_ready(rdy_a), .in_sop(in_sop),
        .in_data(in_data), .out_valid(ov_a), .out_ready(out_ready), .out_symid(sym_a),
        .out_price(pr_a), .out_vol(vol_a), .out_type(ty_a), .pass_cnt(pass_a),
        .drop_cnt(drop_a), .err_cnt(err_a)
    );

    t2t_msg_seq #(.FILTER_EN(1'b0)) dut_b (
        .clk(clk), .reset(reset), .in_valid(vld[1]), .in_ready(rdy_b), .in_sop(in_sop),
        .in_data(in_data), .out_valid(ov_b), .out_ready(out_ready), .out_symid(sym_b),
        .out_price(pr_b), .out_vol(vol_b), .out_type(ty_b), .pass_cnt(pass_b),
        .drop_cnt(drop_b), .err_cnt(err_b)
    );

    t2t_msg_seq #(.CNT_WIDTH(4)) dut_c (
        .clk(clk), .reset(reset), .in_valid(vld[2]), .in_ready(rdy_c), .in_sop(in_sop),
        .in_data(in_data), .out_valid(ov_c), .out_ready(out_ready), .out_symid(sym_c),
        .out_price(pr_c), .out_vol(vol_c), .out_type(ty_c), .pass_cnt(pass_c),
        .drop_cnt(drop_c), .err_cnt(err_c)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic mon_pop(input int idx, input logic [15:0] s, input logic [63:0] p,
                           input logic [31:0] v, input logic [23:0] t);
        rec_t e;
        int   sz;
        sz = (idx == 0) ? q_a.size() : (idx == 1) ? q_b.size() : q_c.size();
        if (sz == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_record dut=%0d: got symid %h type %h expected none", idx, s, t);
        end else begin
            e = (idx == 0) ? q_a.pop_front() : (idx == 1) ? q_b.pop_front() : q_c.pop_front();
            chk($sformatf("rec%0d_symid", idx), s, e.symid);
            chk($sformatf("rec%0d_price", idx), p, e.price);
            chk($sformatf("rec%0d_vol", idx), v, e.vol);
            chk($sformatf("rec%0d_type", idx), t, e.ty);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && out_ready) begin
            if (ov_a) mon_pop(0, sym_a, pr_a, vol_a, ty_a);
            if (ov_b) mon_pop(1, sym_b, pr_b, vol_b, ty_b);
            if (ov_c) mon_pop(2, sym_c, pr_c, vol_c, ty_c);
        end
    end

    function automatic logic rdy(input int sel);
        return (sel == 0) ? rdy_a : (sel == 1) ? rdy_b : rdy_c;
    endfunction

    task automatic send(input int sel, input logic sop, input logic [63:0] d);
        int n;
        @(negedge clk);
        in_sop   = sop;
        in_data  = d;
        vld      = 3'b000;
        vld[sel] = 1'b1;
        n = 0;
        while (!rdy(sel) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout dut=%0d: in_ready stayed 0, required 1 within 50 cycles", sel);
        end
        @(posedge clk);
        #1 vld = 3'b000;
    endtask

    task automatic send_msg(input int sel, input logic [63:0] b1, input logic [63:0] b2,
                            input logic [63:0] b3);
        send(sel, 1'b1, b1);
        send(sel, 1'b0, b2);
        send(sel, 1'b0, b3);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        next_cycle();
        chk("rst_out_valid", ov_a, 1'b0);
        chk("rst_in_ready", rdy_a, 1'b1);
        chk("rst_symid", sym_a, 16'h0);
        chk("rst_price", pr_a, 64'h0);
        chk("rst_vol", vol_a, 32'h0);
        chk("rst_type", ty_a, 24'h0);
        chk("rst_pass", pass_a, 16'h0);
        chk("rst_drop", drop_a, 16'h0);
        chk("rst_err", err_a, 16'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{64'h4E4557_1234_ABCDEF, 64'h0102030405_AABBCC, 64'hDD00000000000000, 1'b1,
                    '{16'h1234, 64'hABCDEF0102030405, 32'hAABBCCDD, 24'h4E4557}, 16'd1, 16'd0};
        vecs[1] = '{64'h43584C_0007_000001, 64'h1111111111_222222, 64'h3300000000000000, 1'b0,
                    '{16'h0, 64'h0, 32'h0, 24'h0}, 16'd1, 16'd1};
        vecs[2] = '{64'h4E4557_FFFF_000000, 64'h0000000000_FFFFFF, 64'hFF12345678ABCDEF, 1'b1,
                    '{16'hFFFF, 64'h0000000000000000, 32'hFFFFFFFF, 24'h4E4557}, 16'd2, 16'd1};
        vecs[3] = '{64'h4E4556_5555_123456, 64'h9999999999_888888, 64'h7700000000000000, 1'b0,
                    '{16'h0, 64'h0, 32'h0, 24'h0}, 16'd2, 16'd2};
        vecs[4] = '{64'h4E4557_00A5_800000, 64'h8000000001_000001, 64'h0100000000000000, 1'b1,
                    '{16'h00A5, 64'h8000008000000001, 32'h00000101, 24'h4E4557}, 16'd3, 16'd2};

        reset     = 1'b1;
        vld       = 3'b000;
        in_sop    = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        next_cycle();
        next_cycle();
        chk("init_out_valid", ov_a, 1'b0);
        chk("init_in_ready", rdy_a, 1'b1);
        chk("init_price", pr_a, 64'h0);
        chk("init_pass", pass_a, 16'h0);
        chk("init_drop", drop_a, 16'h0);
        chk("init_err", err_a, 16'h0);
        @(negedge clk);
        reset = 1'b0;

        // Table of whole messages on the filtering instance
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].emit) q_a.push_back(vecs[i].exp);
            send_msg(0, vecs[i].b1, vecs[i].b2, vecs[i].b3);
            if (vecs[i].emit) begin
                chk($sformatf("v%0d_valid_after_beat3", i), ov_a, 1'b1);
            end else begin
                chk($sformatf("v%0d_no_valid", i), ov_a, 1'b0);
                chk($sformatf("v%0d_in_ready", i), rdy_a, 1'b1);
            end
            next_cycle();
            chk($sformatf("v%0d_valid_low", i), ov_a, 1'b0);
            chk($sformatf("v%0d_pass", i), pass_a, vecs[i].pass_e);
            chk($sformatf("v%0d_drop", i), drop_a, vecs[i].drop_e);
            chk($sformatf("v%0d_err", i), err_a, 16'h0);
        end

        // Filter disabled: non-NEW type is forwarded
        q_b.push_back('{16'h0007, 64'h0000011111111111, 32'h22222233, 24'h43584C});
        send_msg(1, 64'h43584C_0007_000001, 64'h1111111111_222222, 64'h3300000000000000);
        next_cycle();
        chk("nofilt_pass", pass_b, 16'd1);
        chk("nofilt_drop", drop_b, 16'd0);
        chk("nofilt_q_empty", q_b.size(), 0);

        // Backpressure: record held for 10 cycles
        out_ready = 1'b0;
        q_a.push_back('{16'hBEEF, 64'h0102030405060708, 32'h090A0B0C, 24'h4E4557});
        send_msg(0, 64'h4E4557_BEEF_010203, 64'h0405060708_090A0B, 64'h0C00000000000000);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_valid", c), ov_a, 1'b1);
            chk($sformatf("bp%0d_in_ready", c), rdy_a, 1'b0);
            chk($sformatf("bp%0d_symid", c), sym_a, 16'hBEEF);
            chk($sformatf("bp%0d_price", c), pr_a, 64'h0102030405060708);
            chk($sformatf("bp%0d_vol", c), vol_a, 32'h090A0B0C);
            chk($sformatf("bp%0d_pass", c), pass_a, 16'd3);
        end
        next_cycle();
        out_ready = 1'b1;
        next_cycle();
        chk("bp_release_pass", pass_a, 16'd4);
        chk("bp_release_valid", ov_a, 1'b0);

        // Framing A: stray non-sop beat in WAIT1
        send(0, 1'b0, 64'hDEADBEEFDEADBEEF);
        next_cycle();
        chk("frmA_err", err_a, 16'd1);
        chk("frmA_valid", ov_a, 1'b0);
        chk("frmA_in_ready", rdy_a, 1'b1);

        // Framing B: sop in WAIT3, then sop in WAIT2 restarting a full message
        pulse_reset();
        send(0, 1'b1, 64'h4E4557_7777_AAAAAA);
        send(0, 1'b0, 64'h5555555555_666666);
        send(0, 1'b1, 64'h4E4557_0101_000000);
        chk("frmB_err_wait3", err_a, 16'd1);
        q_a.push_back('{16'h0202, 64'h123456FEDCBA9876, 32'h54321010, 24'h4E4557});
        send_msg(0, 64'h4E4557_0202_123456, 64'hFEDCBA9876_543210, 64'h1000000000000000);
        next_cycle();
        chk("frmB_err", err_a, 16'd2);
        chk("frmB_pass", pass_a, 16'd1);

        // Reset mid-message, then a fresh record
        send(0, 1'b1, 64'h4E4557_3333_333333);
        send(0, 1'b0, 64'h3333333333_333333);
        chk("midrst_q_a_empty", q_a.size(), 0);
        chk("midrst_q_b_empty", q_b.size(), 0);
        pulse_reset();
        q_a.push_back('{16'h4444, 64'h0000AA00000000BB, 32'h0000CCDD, 24'h4E4557});
        send_msg(0, 64'h4E4557_4444_0000AA, 64'h00000000BB_0000CC, 64'hDD00000000000000);
        next_cycle();
        chk("midrst_pass", pass_a, 16'd1);
        chk("midrst_err", err_a, 16'd0);

        // Saturation on the 4-bit instance
        for (int m = 0; m < 20; m++) begin
            send_msg(2, 64'h414444_0000_000000 | 64'(m), 64'h0, 64'h0);
            chk($sformatf("sat%0d_drop", m), drop_c, (m + 1 > 15) ? 4'hF : 4'(m + 1));
            chk($sformatf("sat%0d_valid", m), ov_c, 1'b0);
        end
        chk("sat_pass", pass_c, 4'h0);
        chk("sat_err", err_c, 4'h0);

        next_cycle();
        chk("end_q_a_empty", q_a.size(), 0);
        chk("end_q_b_empty", q_b.size(), 0);
        chk("end_q_c_empty", q_c.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
